load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Initiator side of the data-memory port. Accepts one load/store request at a time from the MEM pipeline stage.
- Translates each request into a single-cycle word-addressed memory access, with byte mask and lane-replicated write data.
- Aligns and sign/zero-extends load data and returns a response over a valid/ready handshake.
- Drives the same request/we_re/address/data_in/mask/data_out port that the data memory responds on.

Parameters:
- ADDR_W, 8, memory word-address width. Byte address bits [ADDR_W+1:2] select the word; higher bits are ignored, so accesses wrap modulo 4*2^ADDR_W bytes.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  unit can accept; equals (state==IDLE)
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  misaligned or illegal funct3
- mem_request  out  1  memory request
- mem_we_re  out  1  1=write, 0=read
- mem_address  out  ADDR_W  word address
- mem_data_in  out  32  write data to memory
- mem_mask  out  4  byte-lane write enables
- mem_data_out  in  32  read data; valid the cycle after the read edge

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_request, mem_we_re, mem_address, mem_data_in, mem_mask, resp_valid, resp_rdata and resp_err all 0.
- Reset mid-operation aborts immediately. A write already sampled by the memory stays committed.
- States: IDLE, ACCESS, LOAD_WAIT, RESP. All mem_* and resp_* outputs are registered.
- IDLE, on req_valid&&req_ready (edge A):
  - Latch funct3, addr[1:0] and the write flag.
  - Legal request: load mem_* regs, mem_request=1, go to ACCESS.
  - Illegal request: resp_err=1, resp_valid=1, resp_rdata=0, go to RESP. No memory access is made.
- Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
- Store mask:
  - SB: 4'b0001<<addr[1:0]
  - SH: 4'b0011<<{addr[1],0}
  - SW: 4'b1111
- Store data: SB is the byte replicated 4x; SH is the halfword replicated 2x; SW is passed through.
- Loads: mem_mask=0, mem_we_re=0.
- ACCESS (edge A+1): mem_request=0.
  - Store: resp_valid=1, resp_err=0, resp_rdata=0, go to RESP.
  - Load: go to LOAD_WAIT.
- LOAD_WAIT (edge A+2): select the byte/half from mem_data_out using the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Register into resp_rdata, resp_valid=1, go to RESP.
- RESP: hold resp_* stable until resp_ready=1. On that edge, clear resp_valid and go to IDLE.
  - No new request is accepted in the same cycle; req_ready is low throughout RESP.
- mem_request is high for exactly one cycle per legal access. mem_data_in and mem_mask are don't-care when mem_request=0 (held at last value).
- Latency from accept to resp_valid:
  - store: 2 cycles
  - load: 3 cycles
  - error: 1 cycle
- resp_ready high on arrival of resp_valid: one cycle of resp_valid, then IDLE.
- req_valid while not IDLE: ignored. The requester must hold it until it sees req_ready.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=0, is an error. Handled as illegal: resp_err=1, no memory access.
- Undefined: misaligned accesses are silently aligned down (halfword uses addr[1] only, word ignores addr[1:0]). The access proceeds normally with resp_err=0.

Test Plan:
- Reset: rst=0 mid-ACCESS -> all outputs 0 immediately, req_ready=1 after release.
- SB, addr=0x0000_0006, wdata=0x0000_00A5 -> one-cycle mem_request, mem_we_re=1, mem_address=1, mem_mask=4'b0100, mem_data_in=0xA5A5A5A5. resp_valid 2 cycles after accept, resp_rdata=0, resp_err=0.
- Loads from word 3 = 0x80F1_7F22 (memory model):
  - LB addr 0x0F -> 0xFFFFFF80
  - LBU addr 0x0F -> 0x00000080
  - LH addr 0x0C -> 0x00007F22
  - LW addr 0x0C -> 0x80F17F22
  - Each returns resp_valid exactly 3 cycles after accept.
- Backpressure: resp_ready=0 for 4 cycles -> resp_valid/resp_rdata held; req_ready=0 and a new req_valid is ignored. On resp_ready=1, return to IDLE next cycle.
- Misaligned LW addr 0x0000_0002:
  - with MISALIGN_TRAP_EN: resp_err=1 after 1 cycle, no mem_request.
  - without: mem_address=0, resp_rdata=word 0, resp_err=0.
- Illegal load funct3=3'b011 -> resp_err=1, resp_rdata=0, no mem_request. Wrap: SW addr 0x0000_0400 (ADDR_W=8) -> mem_address=0.

Source files
------------

// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Initiator side of the data-memory port. Turns one RV32I
//               load/store request at a time into a single-cycle word access
//               (byte mask, lane-replicated write data), then aligns and
//               sign/zero-extends load data into a valid/ready response.
//               Optional macro MISALIGN_TRAP_EN: misaligned halfword/word
//               accesses are reported as errors instead of being aligned down.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,           // asynchronous, active-low
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic [3:0]        mem_mask,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ACCESS    = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_we;

  logic        w_illegal;
  logic        w_misalign;
  logic        w_reject;
  logic [3:0]  w_mask;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // Byte-address bits above the word index wrap away by design.
  logic        w_unused_addr;
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_ready = (r_state == S_IDLE);

  // Decode legality, byte mask and replicated write data of the offered request.
  always_comb begin
    w_illegal = 1'b0;
    if (req_we) begin
      w_illegal = (req_funct3 > 3'b010);
    end else begin
      w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end

`ifdef MISALIGN_TRAP_EN
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif

    w_reject = w_illegal || w_misalign;

    case (req_funct3[1:0])
      2'b00: begin
        w_mask  = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_mask  = 4'b0011 << {req_addr[1], 1'b0};
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_mask  = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Pick the addressed byte/halfword from the returned word and extend it.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_data_out[7:0];
      2'd1:    w_byte = mem_data_out[15:8];
      2'd2:    w_byte = mem_data_out[23:16];
      default: w_byte = mem_data_out[31:24];
    endcase
    w_half = r_off[1] ? mem_data_out[31:16] : mem_data_out[15:0];

    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_data_out;
    endcase
  end

  // Request/response sequencer; every mem_* and resp_* output is a register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      r_we        <= 1'b0;
      mem_request <= 1'b0;
      mem_we_re   <= 1'b0;
      mem_address <= '0;
      mem_data_in <= 32'd0;
      mem_mask    <= 4'd0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 32'd0;
      resp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_funct3 <= req_funct3;
            r_off    <= req_addr[1:0];
            r_we     <= req_we;
            if (w_reject) begin
              // Rejected requests never touch memory.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              r_state    <= S_RESP;
            end else begin
              mem_request <= 1'b1;
              mem_we_re   <= req_we;
              mem_address <= req_addr[ADDR_W+1:2];
              if (req_we) begin
                mem_mask    <= w_mask;
                mem_data_in <= w_wdata;
              end else begin
                mem_mask <= 4'd0;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          mem_request <= 1'b0;
          if (r_we) begin
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            r_state    <= S_RESP;
          end else begin
            r_state <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          resp_rdata <= w_load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               synchronous word memory model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'd0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_request;
  logic              mem_we_re;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_data_out = 32'd0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_request  (mem_request),
    .mem_we_re    (mem_we_re),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_mask     (mem_mask),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  // Synchronous word memory: masked writes, read data valid after the read edge.
  logic [31:0] mem [256];
  int          n_pulses = 0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[0] = 32'h1122_3344;
    mem[3] = 32'h80F1_7F22;
  end

  always @(posedge clk) begin
    if (mem_request) begin
      n_pulses++;
      if (mem_we_re) begin
        for (int i = 0; i < 4; i++)
          if (mem_mask[i]) mem[mem_address][8*i +: 8] <= mem_data_in[8*i +: 8];
      end else begin
        mem_data_out <= mem[mem_address];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  logic        snap_req;
  logic        snap_we;
  logic [ADDR_W-1:0] snap_addr;
  logic [3:0]  snap_mask;
  logic [31:0] snap_data;
  int          last_pulses;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Issue one request, capture the memory-side strobe, and score the response.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int hold);
    exp_t e;
    int   w;
    int   lat;
    int   p0;
    sb_q.push_back('{rdata: exp_rd, err: exp_err, lat: exp_lat});
    @(negedge clk);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_req_ready"}, req_ready, 1'b1);
    p0 = n_pulses;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    snap_req  = mem_request;
    snap_we   = mem_we_re;
    snap_addr = mem_address;
    snap_mask = mem_mask;
    snap_data = mem_data_in;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb_q.pop_front();
    check({tag, "_resp_valid"}, resp_valid, 1'b1);
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_err"}, resp_err, e.err);
    check({tag, "_latency"}, lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_0020;
      req_wdata  = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, resp_valid, 1'b1);
      check({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      check({tag, "_hold_req_ready"}, req_ready, 1'b0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_released"}, resp_valid, 1'b0);
    check({tag, "_idle"}, req_ready, 1'b1);
    last_pulses = n_pulses - p0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_request", mem_request, 1'b0);
    check("rst_mem_mask", mem_mask, 4'd0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // SB byte 2 of word 1
    do_req("sb", 1'b1, 3'b000, 32'h0000_0006, 32'h0000_00A5, 32'd0, 1'b0, 2, 0);
    check("sb_mem_request", snap_req, 1'b1);
    check("sb_mem_we_re", snap_we, 1'b1);
    check("sb_mem_address", snap_addr, 8'd1);
    check("sb_mem_mask", snap_mask, 4'b0100);
    check("sb_mem_data_in", snap_data, 32'hA5A5_A5A5);
    check("sb_pulses", last_pulses, 1);

    // Loads from word 3 = 0x80F17F22
    do_req("lb", 1'b0, 3'b000, 32'h0000_000F, 32'd0, 32'hFFFF_FF80, 1'b0, 3, 0);
    check("lb_mem_we_re", snap_we, 1'b0);
    check("lb_mem_mask", snap_mask, 4'd0);
    check("lb_mem_address", snap_addr, 8'd3);
    check("lb_pulses", last_pulses, 1);
    do_req("lbu", 1'b0, 3'b100, 32'h0000_000F, 32'd0, 32'h0000_0080, 1'b0, 3, 0);
    do_req("lh", 1'b0, 3'b001, 32'h0000_000C, 32'd0, 32'h0000_7F22, 1'b0, 3, 0);
    do_req("lh_hi", 1'b0, 3'b001, 32'h0000_000E, 32'd0, 32'hFFFF_80F1, 1'b0, 3, 0);
    do_req("lhu_hi", 1'b0, 3'b101, 32'h0000_000E, 32'd0, 32'h0000_80F1, 1'b0, 3, 0);
    // LW with 4 cycles of backpressure and an ignored stray request
    do_req("lw_bp", 1'b0, 3'b010, 32'h0000_000C, 32'd0, 32'h80F1_7F22, 1'b0, 3, 4);
    check("lw_bp_pulses", last_pulses, 1);

    // Read back the stored byte
    do_req("lb_sb", 1'b0, 3'b000, 32'h0000_0006, 32'd0, 32'hFFFF_FFA5, 1'b0, 3, 0);

    // SH upper half of word 4, then read the word
    do_req("sh", 1'b1, 3'b001, 32'h0000_0012, 32'h1234_BEEF, 32'd0, 1'b0, 2, 0);
    check("sh_mem_mask", snap_mask, 4'b1100);
    check("sh_mem_data_in", snap_data, 32'hBEEF_BEEF);
    do_req("lw_sh", 1'b0, 3'b010, 32'h0000_0010, 32'd0, 32'hBEEF_0000, 1'b0, 3, 0);

    // Misaligned LW
`ifdef MISALIGN_TRAP_EN
    do_req("lw_mis", 1'b0, 3'b010, 32'h0000_0002, 32'd0, 32'd0, 1'b1, 1, 0);
    check("lw_mis_pulses", last_pulses, 0);
`else
    do_req("lw_mis", 1'b0, 3'b010, 32'h0000_0002, 32'd0, 32'h1122_3344, 1'b0, 3, 0);
    check("lw_mis_mem_address", snap_addr, 8'd0);
    check("lw_mis_pulses", last_pulses, 1);
`endif

    // Illegal funct3 for a load and for a store
    do_req("ill_ld", 1'b0, 3'b011, 32'h0000_000C, 32'd0, 32'd0, 1'b1, 1, 0);
    check("ill_ld_pulses", last_pulses, 0);
    do_req("ill_st", 1'b1, 3'b011, 32'h0000_000C, 32'h5555_5555, 32'd0, 1'b1, 1, 0);
    check("ill_st_pulses", last_pulses, 0);

    // Address wrap: byte 0x400 is word 0 with an 8-bit word address
    do_req("sw_wrap", 1'b1, 3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 0);
    check("sw_wrap_mem_address", snap_addr, 8'd0);
    check("sw_wrap_mem_mask", snap_mask, 4'b1111);
    do_req("lw_wrap", 1'b0, 3'b010, 32'h0000_0000, 32'd0, 32'hDEAD_BEEF, 1'b0, 3, 0);

    // Reset in the middle of an access
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_000C;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("mid_mem_request", mem_request, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_mem_request", mem_request, 1'b0);
    check("arst_mem_address", mem_address, 8'd0);
    check("arst_mem_data_in", mem_data_in, 32'd0);
    check("arst_mem_mask", mem_mask, 4'd0);
    check("arst_mem_we_re", mem_we_re, 1'b0);
    check("arst_resp_valid", resp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_req_ready", req_ready, 1'b1);
    do_req("lw_after_rst", 1'b0, 3'b010, 32'h0000_000C, 32'd0, 32'h80F1_7F22, 1'b0, 3, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
